sprite_plot_scheduler: RTL and testbench

//  Shares the single VGA adapter pixel port among NUM_REQ sprite plot FSMs (user, alien, bullet drawers).

---
 rtl/sprite_plot_scheduler.sv | 146 ++++++++++++++
 tb/tb_sprite_plot_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sprite_plot_scheduler.sv
// Sprite plot scheduler: once per frame, grants the shared VGA pixel port to
// each requesting sprite FSM in fixed priority order (index 0 first), pulses
// its enable, forwards its pixel stream until done or timeout, then moves on.
module sprite_plot_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned X_W     = 9,
  parameter int unsigned Y_W     = 8,
  parameter int unsigned C_W     = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   frame_tick,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     done_in,
  input  logic [NUM_REQ-1:0]     plot_in,
  input  logic [NUM_REQ*X_W-1:0] x_in,
  input  logic [NUM_REQ*Y_W-1:0] y_in,
  input  logic [NUM_REQ*C_W-1:0] colour_in,
  output logic [NUM_REQ-1:0]     enable_out,
  output logic [X_W-1:0]         x_out,
  output logic [Y_W-1:0]         y_out,
  output logic [C_W-1:0]         colour_out,
  output logic                   writeEn,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun,
  output logic                   timeout_err
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_FDONE = 3'd4;

  logic [2:0]         state_q,   state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]   grant_q,   grant_d;
  logic [TMR_W-1:0]   timer_q,   timer_d;
  logic               overrun_q, overrun_d;
  logic               tmo_q,     tmo_d;
  logic [IDX_W-1:0]   low_idx;

  // Lowest set bit of the pending mask; scanned downward so the lowest index wins.
  always_comb begin
    low_idx = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (pending_q[i-1]) low_idx = IDX_W'(i - 1);
    end
  end

  // Next-state logic for the pass FSM, grant timer and sticky fault flags.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    grant_d   = grant_q;
    timer_d   = timer_q;
    overrun_d = overrun_q;
    tmo_d     = tmo_q;

    if (frame_tick && (state_q != S_IDLE)) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          pending_d = req;
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (pending_q == '0) begin
          state_d = S_FDONE;
        end else begin
          grant_d = low_idx;
          state_d = S_START;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done takes precedence over an expiring timer in the same cycle
        if (done_in[grant_q]) begin
          pending_d[grant_q] = 1'b0;
          state_d            = S_SCAN;
        end else if (timer_q == TMR_W'(TIMEOUT)) begin
          tmo_d              = 1'b1;
          pending_d[grant_q] = 1'b0;
          state_d            = S_SCAN;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_FDONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      timer_q   <= '0;
      overrun_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      timer_q   <= timer_d;
      overrun_q <= overrun_d;
      tmo_q     <= tmo_d;
    end
  end

  // Enable pulse and zero-latency pixel mux from the granted requester.
  always_comb begin
    enable_out = '0;
    x_out      = '0;
    y_out      = '0;
    colour_out = '0;
    writeEn    = 1'b0;
    if (state_q == S_START) enable_out[grant_q] = 1'b1;
    if (state_q == S_WAIT) begin
      x_out      = x_in[grant_q*X_W +: X_W];
      y_out      = y_in[grant_q*Y_W +: Y_W];
      colour_out = colour_in[grant_q*C_W +: C_W];
      writeEn    = plot_in[grant_q];
    end
  end

  assign grant_idx   = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = (state_q == S_FDONE);
  assign overrun     = overrun_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_sprite_plot_scheduler.sv
// Directed bench for sprite_plot_scheduler: empty frame, two-grant frame with
// ignored foreign done / overrun / mid-pass req change, done-on-timeout-cycle,
// real timeout, and reset in the middle of a grant.
module tb_sprite_plot_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic        frame_tick;
  logic [3:0]  req, done_in, plot_in;
  logic [35:0] x_in;
  logic [31:0] y_in;
  logic [11:0] colour_in;
  logic [3:0]  enable_out;
  logic [8:0]  x_out;
  logic [7:0]  y_out;
  logic [2:0]  colour_out;
  logic        writeEn, busy, frame_done, overrun, timeout_err;
  logic [1:0]  grant_idx;

  int total = 0;
  int bad   = 0;

  sprite_plot_scheduler #(.NUM_REQ(4), .IDX_W(2), .TIMEOUT(1023), .X_W(9), .Y_W(8), .C_W(3)) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .req(req),
    .done_in(done_in), .plot_in(plot_in), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in), .enable_out(enable_out), .x_out(x_out),
    .y_out(y_out), .colour_out(colour_out), .writeEn(writeEn),
    .grant_idx(grant_idx), .busy(busy), .frame_done(frame_done),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; frame_tick = 1'b0; req = '0; done_in = '0; plot_in = '0;
    x_in      = {9'd333, 9'd222, 9'd111, 9'd5};
    y_in      = {8'd44, 8'd33, 8'd22, 8'd11};
    colour_in = {3'd4, 3'd3, 3'd2, 3'd1};
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_en", enable_out, 0);
    chk("rst_we", writeEn, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_flags", {overrun, timeout_err, frame_done}, 0);
    resetn = 1'b1;
    step();

    // empty frame: tick cycle t, SCAN t+1, FDONE t+2
    frame_tick = 1'b1; req = 4'b0000;
    step(); frame_tick = 1'b0; #1;
    chk("e_scan_busy", busy, 1);
    chk("e_scan_fd", frame_done, 0);
    step();
    chk("e_fdone", frame_done, 1);
    chk("e_fdone_en", enable_out, 0);
    chk("e_fdone_we", writeEn, 0);
    step();
    chk("e_idle_busy", busy, 0);
    chk("e_idle_fd", frame_done, 0);

    // two-grant frame, req=0101, FSM0 done 560 cycles after its enable
    frame_tick = 1'b1; req = 4'b0101; plot_in = 4'b1111;
    step(); frame_tick = 1'b0; #1;                     // SCAN
    step();                                            // START for 0
    chk("f_en0", enable_out, 4'b0001);
    chk("f_g0", grant_idx, 0);
    chk("f_start_we", writeEn, 0);
    chk("f_start_x", x_out, 0);
    step();                                            // WAIT cycle 0
    chk("f_en_off", enable_out, 0);
    chk("f_w_we", writeEn, 1);
    chk("f_w_pix", {x_out, y_out, colour_out}, {9'd5, 8'd11, 3'd1});
    plot_in = 4'b0100; #1;
    chk("f_foreign_plot", writeEn, 0);
    repeat (100) step();                               // WAIT cycle 100
    done_in = 4'b1000; frame_tick = 1'b1; #1;
    step();                                            // WAIT cycle 101
    done_in = '0; frame_tick = 1'b0; req = 4'b1111; #1;
    chk("f_foreign_done_busy", busy, 1);
    chk("f_foreign_done_grant", grant_idx, 0);
    chk("f_foreign_done_en", enable_out, 0);
    chk("f_overrun", overrun, 1);
    repeat (458) step();                               // WAIT cycle 559
    done_in = 4'b0001; plot_in = 4'b0001; #1;
    chk("f_done_pixel_we", writeEn, 1);
    chk("f_done_pixel_x", x_out, 5);
    step(); done_in = '0; #1;                          // SCAN
    chk("f_scan_en", enable_out, 0);
    chk("f_scan_busy", busy, 1);
    step();                                            // START for 2
    chk("f_en2", enable_out, 4'b0100);
    chk("f_g2", grant_idx, 2);
    step();                                            // WAIT for 2
    plot_in = 4'b0100; #1;
    chk("f_w2_pix", {writeEn, x_out, y_out, colour_out}, {1'b1, 9'd222, 8'd33, 3'd3});
    plot_in = 4'b0001; #1;
    chk("f_w2_foreign_plot", writeEn, 0);
    done_in = 4'b0100; #1;
    step(); done_in = '0; plot_in = '0; #1;            // SCAN (pending empty despite req change)
    chk("f_scan2_fd", frame_done, 0);
    step();
    chk("f_fdone", frame_done, 1);
    chk("f_fdone_en", enable_out, 0);
    step();
    chk("f_idle", {busy, frame_done}, 0);
    chk("f_tmo_clear", timeout_err, 0);

    // done coinciding with the timeout cycle: no timeout flagged
    frame_tick = 1'b1; req = 4'b0001;
    step(); frame_tick = 1'b0; #1;                     // SCAN
    step();                                            // START
    chk("d_en0", enable_out, 4'b0001);
    step();                                            // WAIT cycle 0
    repeat (1023) step();                              // WAIT cycle 1023
    chk("d_still_wait", busy, 1);
    done_in = 4'b0001; #1;
    step(); done_in = '0; #1;                          // SCAN
    chk("d_no_tmo", timeout_err, 0);
    step();
    chk("d_fdone", frame_done, 1);
    step();

    // real timeout on requester 1
    frame_tick = 1'b1; req = 4'b0010; plot_in = 4'b0010;
    step(); frame_tick = 1'b0; #1;                     // SCAN
    step();                                            // START
    chk("t_en1", enable_out, 4'b0010);
    chk("t_g1", grant_idx, 1);
    step();                                            // WAIT cycle 0
    chk("t_w_x", x_out, 111);
    repeat (1023) step();                              // WAIT cycle 1023
    chk("t_pre_tmo", timeout_err, 0);
    chk("t_pre_we", writeEn, 1);
    step();                                            // SCAN
    chk("t_tmo", timeout_err, 1);
    chk("t_scan_we", writeEn, 0);
    step();
    chk("t_fdone", frame_done, 1);
    step();
    chk("t_idle", busy, 0);

    // reset in the middle of a grant
    frame_tick = 1'b1; req = 4'b1000; plot_in = 4'b1000;
    step(); frame_tick = 1'b0; #1;
    step(); step(); step();                            // WAIT cycle 1
    chk("r_wait_we", writeEn, 1);
    chk("r_wait_g", grant_idx, 3);
    resetn = 1'b0; #1;
    chk("r_async_out", {busy, writeEn, enable_out, x_out, grant_idx}, 0);
    chk("r_async_flags", {overrun, timeout_err, frame_done}, 0);
    step(); resetn = 1'b1;
    step(); step();
    chk("r_stay_idle", {busy, writeEn, enable_out}, 0);
    frame_tick = 1'b1; req = 4'b0100;
    step(); frame_tick = 1'b0; #1;
    chk("r_new_pass", busy, 1);
    step();
    chk("r_new_en", enable_out, 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
